// File: rtl/wb_tdp_bram_bytesel.sv
`default_nettype none
// ============================================================================
// Module   : wb_tdp_bram_bytesel
// Purpose  : True dual-port block RAM behind two independent Wishbone B4
//            pipelined slave ports (A and B) sharing one clock. Byte-lane
//            write enables, read-first data, deterministic same-address
//            write collision handling and out-of-range error termination.
// Revision : 1.0 - initial release
//
// Parameters
//   DW     data width in bits (multiple of 8, >= 8)
//   AW     word-address width
//   DEPTH  number of words, 1 <= DEPTH <= 2**AW
//   A_WINS 1: port A owns overlapping bytes on a same-address double write,
//          0: port B owns them
//
// Ports (x = a | b)
//   i_clk        clock, rising edge
//   i_reset_n    asynchronous active-low reset
//   i_x_cyc      bus cycle
//   i_x_stb      strobe (request accepted on cyc & stb)
//   i_x_we       write enable
//   i_x_addr     word address [AW-1:0]
//   i_x_data     write data [DW-1:0]
//   i_x_sel      byte selects [DW/8-1:0]
//   o_x_stall    always 0
//   o_x_ack      acknowledge, masked by i_x_cyc
//   o_x_err      error (addr >= DEPTH), masked by i_x_cyc
//   o_x_data     read data (old word contents of the last in-range access)
//
// Build option
//   WB_TDP_BRAM_OREG_EN  adds an output register stage per port; ack/err
//                        latency becomes two cycles.
// ============================================================================
module wb_tdp_bram_bytesel #(
    parameter int DW     = 32,
    parameter int AW     = 10,
    parameter int DEPTH  = 1024,
    parameter int A_WINS = 1
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_a_cyc,
    input  logic            i_a_stb,
    input  logic            i_a_we,
    input  logic [AW-1:0]   i_a_addr,
    input  logic [DW-1:0]   i_a_data,
    input  logic [DW/8-1:0] i_a_sel,
    output logic            o_a_stall,
    output logic            o_a_ack,
    output logic            o_a_err,
    output logic [DW-1:0]   o_a_data,
    input  logic            i_b_cyc,
    input  logic            i_b_stb,
    input  logic            i_b_we,
    input  logic [AW-1:0]   i_b_addr,
    input  logic [DW-1:0]   i_b_data,
    input  logic [DW/8-1:0] i_b_sel,
    output logic            o_b_stall,
    output logic            o_b_ack,
    output logic            o_b_err,
    output logic [DW-1:0]   o_b_data
);

    localparam int          c_NB    = DW / 8;
    // One extra bit so DEPTH = 2**AW is representable and the check folds away.
    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    logic [DW-1:0] r_mem [0:DEPTH-1];

    logic w_a_req, w_a_inr, w_a_ok, w_a_bad, w_a_wr;
    logic w_b_req, w_b_inr, w_b_ok, w_b_bad, w_b_wr;

    assign w_a_req = i_a_cyc & i_a_stb;
    assign w_a_inr = ({1'b0, i_a_addr} < c_DEPTH);
    assign w_a_ok  = w_a_req & w_a_inr;
    assign w_a_bad = w_a_req & ~w_a_inr;
    assign w_a_wr  = w_a_ok & i_a_we;

    assign w_b_req = i_b_cyc & i_b_stb;
    assign w_b_inr = ({1'b0, i_b_addr} < c_DEPTH);
    assign w_b_ok  = w_b_req & w_b_inr;
    assign w_b_bad = w_b_req & ~w_b_inr;
    assign w_b_wr  = w_b_ok & i_b_we;

    // Memory array: never reset. Both ports' lane writes sit in one process;
    // the port that should win an overlapping lane is written last, so its
    // non-blocking update takes effect. Distinct addresses do not interact.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < c_NB; k++) begin
            if (A_WINS != 0) begin
                if (w_b_wr && i_b_sel[k]) r_mem[i_b_addr][8*k +: 8] <= i_b_data[8*k +: 8];
                if (w_a_wr && i_a_sel[k]) r_mem[i_a_addr][8*k +: 8] <= i_a_data[8*k +: 8];
            end else begin
                if (w_a_wr && i_a_sel[k]) r_mem[i_a_addr][8*k +: 8] <= i_a_data[8*k +: 8];
                if (w_b_wr && i_b_sel[k]) r_mem[i_b_addr][8*k +: 8] <= i_b_data[8*k +: 8];
            end
        end
    end

    // First response stage. The read samples the array before this edge's
    // writes land, which gives read-first behaviour on both ports.
    logic          r_a_ack, r_a_err, r_b_ack, r_b_err;
    logic [DW-1:0] r_a_data, r_b_data;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_a_ack  <= 1'b0;
            r_a_err  <= 1'b0;
            r_a_data <= '0;
            r_b_ack  <= 1'b0;
            r_b_err  <= 1'b0;
            r_b_data <= '0;
        end else begin
            r_a_ack <= w_a_ok;
            r_a_err <= w_a_bad;
            r_b_ack <= w_b_ok;
            r_b_err <= w_b_bad;
            if (w_a_ok) r_a_data <= r_mem[i_a_addr];
            if (w_b_ok) r_b_data <= r_mem[i_b_addr];
        end
    end

`ifdef WB_TDP_BRAM_OREG_EN
    // Second stage: a stage-1 response is discarded if its master has
    // already dropped cyc, so an abandoned cycle never acks late.
    logic          r_a_ack2, r_a_err2, r_b_ack2, r_b_err2;
    logic [DW-1:0] r_a_data2, r_b_data2;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_a_ack2  <= 1'b0;
            r_a_err2  <= 1'b0;
            r_a_data2 <= '0;
            r_b_ack2  <= 1'b0;
            r_b_err2  <= 1'b0;
            r_b_data2 <= '0;
        end else begin
            r_a_ack2  <= r_a_ack & i_a_cyc;
            r_a_err2  <= r_a_err & i_a_cyc;
            r_a_data2 <= r_a_data;
            r_b_ack2  <= r_b_ack & i_b_cyc;
            r_b_err2  <= r_b_err & i_b_cyc;
            r_b_data2 <= r_b_data;
        end
    end

    assign o_a_ack  = r_a_ack2 & i_a_cyc;
    assign o_a_err  = r_a_err2 & i_a_cyc;
    assign o_a_data = r_a_data2;
    assign o_b_ack  = r_b_ack2 & i_b_cyc;
    assign o_b_err  = r_b_err2 & i_b_cyc;
    assign o_b_data = r_b_data2;
`else
    assign o_a_ack  = r_a_ack & i_a_cyc;
    assign o_a_err  = r_a_err & i_a_cyc;
    assign o_a_data = r_a_data;
    assign o_b_ack  = r_b_ack & i_b_cyc;
    assign o_b_err  = r_b_err & i_b_cyc;
    assign o_b_data = r_b_data;
`endif

    assign o_a_stall = 1'b0;
    assign o_b_stall = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_wb_tdp_bram_bytesel.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_tdp_bram_bytesel
// Purpose  : Self-checking bench for wb_tdp_bram_bytesel (DW=32, AW=10,
//            DEPTH=1000, A_WINS=1). A transaction-level model predicts
//            ack/err/data per port every cycle; directed vectors add
//            hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_tdp_bram_bytesel;

    localparam int DEPTH = 1000;
    localparam int A_WINS = 1;
`ifdef WB_TDP_BRAM_OREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int NMAX = 4096;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_cyc = 0, a_stb = 0, a_we = 0, b_cyc = 0, b_stb = 0, b_we = 0;
    logic [9:0]  a_addr = 0, b_addr = 0;
    logic [31:0] a_data = 0, b_data = 0;
    logic [3:0]  a_sel = 0, b_sel = 0;
    logic        a_stall, a_ack, a_err, b_stall, b_ack, b_err;
    logic [31:0] a_q, b_q;

    wb_tdp_bram_bytesel #(.DW(32), .AW(10), .DEPTH(DEPTH), .A_WINS(A_WINS)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we), .i_a_addr(a_addr),
        .i_a_data(a_data), .i_a_sel(a_sel), .o_a_stall(a_stall), .o_a_ack(a_ack),
        .o_a_err(a_err), .o_a_data(a_q),
        .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we), .i_b_addr(b_addr),
        .i_b_data(b_data), .i_b_sel(b_sel), .o_b_stall(b_stall), .o_b_ack(b_ack),
        .o_b_err(b_err), .o_b_data(b_q)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    int          n = 0;          // rising edges seen
    int          rst_mark = 0;   // edge count when reset was last asserted
    bit          okh [2][NMAX];  // accepted in-range request at edge
    bit          erh [2][NMAX];  // accepted out-of-range request at edge
    bit          cych[2][NMAX];  // cyc sampled at edge
    logic [31:0] dath[2][NMAX];  // old word captured (or held) after edge
    bit          dkn [2][NMAX];  // captured word is a known value
    bit   [31:0] mem [int];

    always @(negedge rst_n) rst_mark = n;

    function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                               input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        for (int k = 0; k < 4; k++)
            r[8*k +: 8] = s[k] ? d[8*k +: 8] : old[8*k +: 8];
        return r;
    endfunction

    always @(posedge clk) begin : model
        bit          cy[2], st[2], we[2], ok[2], wr[2];
        int          ad[2];
        logic [31:0] wd[2], w;
        logic [3:0]  sl[2];
        n++;
        cy[0] = a_cyc; st[0] = a_stb; we[0] = a_we; ad[0] = int'(a_addr); wd[0] = a_data; sl[0] = a_sel;
        cy[1] = b_cyc; st[1] = b_stb; we[1] = b_we; ad[1] = int'(b_addr); wd[1] = b_data; sl[1] = b_sel;
        for (int p = 0; p < 2; p++) begin
            ok[p]      = cy[p] && st[p] && (ad[p] < DEPTH);
            wr[p]      = ok[p] && we[p];
            cych[p][n] = cy[p];
            okh[p][n]  = rst_n && ok[p];
            erh[p][n]  = rst_n && cy[p] && st[p] && !(ad[p] < DEPTH);
            if (!rst_n || (n - 1 <= rst_mark && !ok[p])) begin
                dath[p][n] = 0; dkn[p][n] = 1;
            end else if (ok[p]) begin
                dkn[p][n]  = mem.exists(ad[p]);
                dath[p][n] = mem.exists(ad[p]) ? mem[ad[p]] : 32'h0;
            end else begin
                dath[p][n] = dath[p][n-1]; dkn[p][n] = dkn[p][n-1];
            end
        end
        if (wr[0] && wr[1] && ad[0] == ad[1]) begin
            w = mem.exists(ad[0]) ? mem[ad[0]] : 32'h0;
            for (int k = 0; k < 4; k++) begin
                if (sl[0][k] && (A_WINS != 0 || !sl[1][k])) w[8*k +: 8] = wd[0][8*k +: 8];
                else if (sl[1][k])                          w[8*k +: 8] = wd[1][8*k +: 8];
            end
            if ((sl[0] | sl[1]) != 0) mem[ad[0]] = w;
        end else begin
            for (int p = 0; p < 2; p++)
                if (wr[p] && sl[p] != 0)
                    mem[ad[p]] = lane_merge(mem.exists(ad[p]) ? mem[ad[p]] : 32'h0, wd[p], sl[p]);
        end
    end

    task automatic cmp_port(input int p, input string nm, input logic cyc, input logic ack,
                            input logic err, input logic stall, input logic [31:0] q);
        int e;
        bit held, ea, ee;
        e = n - LAT + 1;
        held = cyc; ea = 0; ee = 0;
        for (int j = e + 1; j <= n; j++) held = held && cych[p][j];
        if (rst_n && e >= 1 && e > rst_mark) begin
            ea = okh[p][e] && held;
            ee = erh[p][e] && held;
        end
        chk({nm, "_ack"}, {31'b0, ack}, {31'b0, ea});
        chk({nm, "_err"}, {31'b0, err}, {31'b0, ee});
        chk({nm, "_stall"}, {31'b0, stall}, 32'h0);
        if (!rst_n || e < 1 || e <= rst_mark) chk({nm, "_data_rst"}, q, 32'h0);
        else if (dkn[p][e])                    chk({nm, "_data"}, q, dath[p][e]);
    endtask

    bit run = 0;
    always @(negedge clk) if (run) begin
        cmp_port(0, "a", a_cyc, a_ack, a_err, a_stall, a_q);
        cmp_port(1, "b", b_cyc, b_ack, b_err, b_stall, b_q);
    end

    // ---------------- stimulus ----------------
    logic        ra_ack, ra_err, rb_ack, rb_err;
    logic [31:0] ra_q, rb_q;

    // Issue one request on each enabled port, sample the responses in the
    // cycle they are due, then return both ports to idle.
    task automatic xfer(input bit ae, input bit awe, input logic [9:0] aad, input logic [31:0] ad,
                        input logic [3:0] as, input bit be, input bit bwe, input logic [9:0] bad,
                        input logic [31:0] bd, input logic [3:0] bs);
        a_cyc = ae; a_stb = ae; a_we = awe; a_addr = aad; a_data = ad; a_sel = as;
        b_cyc = be; b_stb = be; b_we = bwe; b_addr = bad; b_data = bd; b_sel = bs;
        @(negedge clk);
        if (LAT == 2) begin
            #1; a_stb = 0; b_stb = 0; a_we = 0; b_we = 0;
            @(negedge clk);
        end
        ra_ack = a_ack; ra_err = a_err; ra_q = a_q;
        rb_ack = b_ack; rb_err = b_err; rb_q = b_q;
        #1;
        a_cyc = 0; a_stb = 0; a_we = 0; b_cyc = 0; b_stb = 0; b_we = 0;
    endtask

    logic [9:0] baddr [4];
    int cnt, idx;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        baddr = '{10'd5, 10'd7, 10'd3, 10'd9};
        rst_n = 0;
        repeat (3) @(negedge clk);
        run = 1;
        #1;
        chk("rst_a_ack", {31'b0, a_ack}, 32'h0);
        chk("rst_a_data", a_q, 32'h0);
        chk("rst_b_err", {31'b0, b_err}, 32'h0);
        rst_n = 1;
        @(negedge clk); #1;

        // Basic write then read-back on A
        xfer(1, 1, 10'd5, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0);
        chk("wr5_ack", {31'b0, ra_ack}, 32'h1);
        chk("wr5_err", {31'b0, ra_err}, 32'h0);
        xfer(1, 0, 10'd5, 0, 0, 0, 0, 0, 0, 0);
        chk("rd5_ack", {31'b0, ra_ack}, 32'h1);
        chk("rd5_data", ra_q, 32'hDEADBEEF);

        // Byte-lane merge across ports
        xfer(1, 1, 10'd7, 32'h11223344, 4'hF, 0, 0, 0, 0, 0);
        xfer(0, 0, 0, 0, 0, 1, 1, 10'd7, 32'hAABBCCDD, 4'h5);
        chk("b_sel5_ack", {31'b0, rb_ack}, 32'h1);
        xfer(1, 0, 10'd7, 0, 0, 0, 0, 0, 0, 0);
        chk("rd7_merge", ra_q, 32'h11BB33DD);

        // Same-cycle double write, A wins overlapping lane 0
        xfer(1, 1, 10'd3, 32'h0, 4'hF, 0, 0, 0, 0, 0);
        xfer(1, 1, 10'd3, 32'h000000FF, 4'h1, 1, 1, 10'd3, 32'h0000EE00, 4'h3);
        chk("coll_a_ack", {31'b0, ra_ack}, 32'h1);
        chk("coll_b_ack", {31'b0, rb_ack}, 32'h1);
        xfer(1, 0, 10'd3, 0, 0, 0, 0, 0, 0, 0);
        chk("rd3_coll", ra_q, 32'h0000EEFF);

        // A writes while B reads the same word: B sees the old word
        xfer(1, 1, 10'd9, 32'h5, 4'hF, 0, 0, 0, 0, 0);
        xfer(1, 1, 10'd9, 32'h6, 4'hF, 1, 0, 10'd9, 0, 0);
        chk("rf_b_old", rb_q, 32'h5);
        xfer(1, 0, 10'd9, 0, 0, 0, 0, 0, 0, 0);
        chk("rf_a_new", ra_q, 32'h6);

        // Range boundary
        xfer(1, 1, 10'd1000, 32'h12345678, 4'hF, 0, 0, 0, 0, 0);
        chk("oor_err", {31'b0, ra_err}, 32'h1);
        chk("oor_noack", {31'b0, ra_ack}, 32'h0);
        chk("oor_hold", ra_q, 32'h6);
        xfer(0, 0, 0, 0, 0, 1, 0, 10'd1023, 0, 0);
        chk("oor1023_err", {31'b0, rb_err}, 32'h1);
        chk("oor1023_hold", rb_q, 32'h5);
        xfer(1, 1, 10'd999, 32'hA5A5A5A5, 4'hF, 0, 0, 0, 0, 0);
        xfer(0, 0, 0, 0, 0, 1, 0, 10'd999, 0, 0);
        chk("rd999_ack", {31'b0, rb_ack}, 32'h1);
        chk("rd999_data", rb_q, 32'hA5A5A5A5);
        xfer(1, 0, 10'd5, 0, 0, 0, 0, 0, 0, 0);
        chk("rd5_after_oor", ra_q, 32'hDEADBEEF);

        // Burst on B, cyc dropped once the second ack is seen
        cnt = 0; idx = 0; b_cyc = 1;
        for (int c = 0; c < 12; c++) begin
            if (idx < 4 && b_cyc) begin
                b_stb = 1; b_we = 0; b_addr = baddr[idx]; idx++;
            end else b_stb = 0;
            @(negedge clk);
            if (b_ack) cnt++;
            #1;
            if (cnt >= 2) begin b_cyc = 0; b_stb = 0; end
        end
        chk("burst_drop_acks", cnt, 32'd2);

        // Reset asserted mid-burst
        b_cyc = 1; b_stb = 1; b_addr = 10'd5;
        @(negedge clk); #1 b_addr = 10'd7;
        @(negedge clk); #1 rst_n = 0;
        #1 chk("rst_mid_ack", {31'b0, b_ack}, 32'h0);
        b_stb = 0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1;
        cnt = 0;
        repeat (4) begin @(negedge clk); if (b_ack) cnt++; end
        chk("rst_release_acks", cnt, 32'd0);
        #1 b_cyc = 0;

        // Write accepted just before reset is retained
        a_cyc = 1; a_stb = 1; a_we = 1; a_addr = 10'd11; a_data = 32'hCAFEF00D; a_sel = 4'hF;
        @(negedge clk); #1 rst_n = 0; a_cyc = 0; a_stb = 0; a_we = 0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1;
        @(negedge clk); #1;
        xfer(1, 0, 10'd11, 0, 0, 0, 0, 0, 0, 0);
        chk("retained_ack", {31'b0, ra_ack}, 32'h1);
        chk("retained_data", ra_q, 32'hCAFEF00D);

        repeat (3) @(negedge clk);
        run = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
